// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered 8-output gate unit among NUM_REQ requesters.
// Latency: acceptance edge E0, gate unit registers at E1, resp_valid rises after E2; one op in flight.
// Backpressure: req_ready only in IDLE; the FSM stalls in RESP until resp_ready, holding the response.
module gate_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [3*NUM_REQ-1:0] req_op,
   input  logic [NUM_REQ-1:0]   req_a,
   input  logic [NUM_REQ-1:0]   req_b,
   output logic                 gu_a,
   output logic                 gu_b,
   input  logic [7:0]           gu_res,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic                 resp_data,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]       state_q,      state_d;
   logic [ID_W-1:0]  rr_ptr_q,     rr_ptr_d;
   logic [2:0]       op_q,         op_d;
   logic             gu_a_q,       gu_a_d;
   logic             gu_b_q,       gu_b_d;
   logic [ID_W-1:0]  resp_id_q,    resp_id_d;
   logic             resp_data_q,  resp_data_d;
   logic             resp_valid_q, resp_valid_d;
   logic [CNT_W-1:0] op_count_q,   op_count_d;

   logic             win_vld;
   logic [ID_W-1:0]  win_idx;
   logic [ID_W-1:0]  win_nxt;
   logic [ID_W:0]    scan_idx;

   // Winner search starting at rr_ptr; scanning downward lets the nearest candidate overwrite farther ones.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
         end
         if (req_valid[scan_idx[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = scan_idx[ID_W-1:0];
         end
      end
   end

   // Pointer after the winner, wrapping at NUM_REQ-1; ready is one-hot only in IDLE and never during reset.
   always_comb begin
      win_nxt   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      req_ready = '0;
      if (rst_n && state_q == S_IDLE && win_vld) begin
         req_ready = NUM_REQ'(1) << win_idx;
      end
   end

   // FSM next state: capture the winner, let the gate unit register, select its result, then hand off.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      op_d         = op_q;
      gu_a_d       = gu_a_q;
      gu_b_d       = gu_b_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = resp_valid_q;
      op_count_d   = op_count_q;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               gu_a_d    = req_a[win_idx];
               gu_b_d    = req_b[win_idx];
               op_d      = req_op[3*int'(win_idx) +: 3];
               resp_id_d = win_idx;
               rr_ptr_d  = win_nxt;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            resp_data_d  = gu_res[op_q];
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
         end
         default: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               if (op_count_q != '1) begin
                  op_count_d = op_count_q + 1'b1;
               end
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State registers; reset abandons any in-flight op and clears every output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         op_q         <= '0;
         gu_a_q       <= 1'b0;
         gu_b_q       <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         op_q         <= op_d;
         gu_a_q       <= gu_a_d;
         gu_b_q       <= gu_b_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         op_count_q   <= op_count_d;
      end
   end

   assign gu_a       = gu_a_q;
   assign gu_b       = gu_b_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_valid = resp_valid_q;
   assign op_count   = op_count_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: scoreboard of expected {id, result} fed from a grant model,
// popped by an independent response monitor; a second instance with a 3-bit counter shares stimulus.
// Inputs driven 1 time unit after posedge; all sampling on negedge.
module tb_gate_unit_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [11:0] req_op;
   logic [3:0]  req_a;
   logic [3:0]  req_b;
   logic        resp_ready;

   logic [3:0]  req_ready,  req_ready_s;
   logic        gu_a,       gu_a_s;
   logic        gu_b,       gu_b_s;
   logic [7:0]  gu_res,     gu_res_s;
   logic        resp_valid, resp_valid_s;
   logic [1:0]  resp_id,    resp_id_s;
   logic        resp_data,  resp_data_s;
   logic        busy,       busy_s;
   logic [15:0] op_count;
   logic [2:0]  op_count_s;

   gate_unit_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .gu_a(gu_a), .gu_b(gu_b),
      .gu_res(gu_res), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .busy(busy), .op_count(op_count)
   );

   gate_unit_arbiter #(.NUM_REQ(4), .CNT_W(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .gu_a(gu_a_s), .gu_b(gu_b_s),
      .gu_res(gu_res_s), .resp_valid(resp_valid_s), .resp_ready(resp_ready),
      .resp_id(resp_id_s), .resp_data(resp_data_s), .busy(busy_s), .op_count(op_count_s)
   );

   // External registered gate units: {NOT_B,NOT_A,XNOR,XOR,NOR,NAND,OR,AND}
   always @(posedge clk) begin
      gu_res   <= {~gu_b, ~gu_a, ~(gu_a ^ gu_b), gu_a ^ gu_b, ~(gu_a | gu_b), ~(gu_a & gu_b), gu_a | gu_b, gu_a & gu_b};
      gu_res_s <= {~gu_b_s, ~gu_a_s, ~(gu_a_s ^ gu_b_s), gu_a_s ^ gu_b_s, ~(gu_a_s | gu_b_s), ~(gu_a_s & gu_b_s), gu_a_s | gu_b_s, gu_a_s & gu_b_s};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_q[$];          // id*2 + expected result bit
   logic [3:0] last_fired;

   // reference model state
   int m_rr, m_since, m_count;
   bit m_inflight;
   logic m_a, m_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_gate(input int op, input logic a, input logic b);
      case (op)
         0: return a & b;
         1: return a | b;
         2: return !(a & b);
         3: return !(a | b);
         4: return a ^ b;
         5: return a == b;
         6: return !a;
         7: return !b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int pick(input logic [3:0] v, input int rr);
      for (int k = 0; k < 4; k++) begin
         if (v[(rr + k) % 4]) return (rr + k) % 4;
      end
      return -1;
   endfunction

   // Grant/timing model: predicts ready, busy, resp_valid, counters; pushes expected responses.
   always @(negedge clk) begin : model_mon
      int w;
      logic [3:0] er;
      if (!rst_n) begin
         m_rr = 0; m_inflight = 0; m_since = 0; m_count = 0; m_a = 0; m_b = 0;
         exp_q.delete();
      end else begin
         if (m_inflight) m_since++;
         w  = pick(req_valid, m_rr);
         er = (!m_inflight && w >= 0) ? 4'(1 << w) : 4'b0;
         check("req_ready", req_ready, er);
         check("busy", busy, m_inflight);
         check("resp_valid", resp_valid, m_inflight && m_since >= 3);
         check("gu_a", gu_a, m_a);
         check("gu_b", gu_b, m_b);
         check("op_count", op_count, m_count);
         check("op_count_sat", op_count_s, (m_count > 7) ? 7 : m_count);
         if (m_inflight) begin
            if (m_since >= 3 && resp_ready) begin
               m_inflight = 0;
               if (m_count < 65535) m_count++;
            end
         end else if (w >= 0) begin
            exp_q.push_back(w * 2 + int'(ref_gate(int'(req_op[3*w +: 3]), req_a[w], req_b[w])));
            m_a = req_a[w];
            m_b = req_b[w];
            m_rr = (w + 1) % 4;
            m_inflight = 1;
            m_since = 0;
         end
      end
   end

   // Response monitor: every presented response must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_unexpected: got id %0d data %0d, required no response", resp_id, resp_data);
         end else begin
            check("resp_id", resp_id, exp_q[0] >> 1);
            check("resp_data", resp_data, exp_q[0] & 1);
            if (resp_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic post(input int i, input int op, input logic a, input logic b);
      if (!req_valid[i]) begin
         req_valid[i]       = 1'b1;
         req_op[3*i +: 3]   = 3'(op);
         req_a[i]           = a;
         req_b[i]           = b;
      end
   endtask

   task automatic step();
      @(negedge clk);
      last_fired = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~last_fired;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((req_valid != 0 || busy) && n < bound) begin
         step();
         n++;
      end
      n_cmp++;
      if (req_valid != 0 || busy) begin
         n_fail++;
         $display("FAIL wait_idle: still busy=%0d valid=%b after %0d cycles, required idle", busy, req_valid, bound);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[$];
      int n;
      logic [3:0] any_fired;
      rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
      last_fired = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_op_count", op_count, 0);
      check("rst_gu_a", gu_a, 0);
      check("rst_gu_b", gu_b, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_data", resp_data, 0);
      rst_n = 1'b1;

      // single XOR op from requester 2
      post(2, 4, 1'b1, 1'b0);
      step();
      check("single_grant", last_fired, 4'b0100);
      wait_idle(50);
      check("single_op_count", op_count, 1);

      // reset while stalled in RESP, with another request pending
      resp_ready = 1'b0;
      post(3, 1, 1'b1, 1'b0);
      n = 0;
      while (!resp_valid && n < 20) begin step(); n++; end
      check("pre_reset_resp_valid", resp_valid, 1);
      post(0, 6, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midresp_rst_resp_valid", resp_valid, 0);
      check("midresp_rst_busy", busy, 0);
      check("midresp_rst_op_count", op_count, 0);
      check("midresp_rst_req_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      resp_ready = 1'b1;

      // round-robin with all requesters continuously valid
      n = 0;
      while (order.size() < 6 && n < 200) begin
         for (int i = 0; i < 4; i++) post(i, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
         step();
         if (last_fired != 0) order.push_back($clog2(last_fired));
         n++;
      end
      check("rr_grant_count", order.size(), 6);
      if (order.size() > 0) check("post_reset_grant", order[0], 0);
      for (int i = 1; i < order.size(); i++) check("rr_order", order[i], i % 4);
      wait_idle(200);

      // back-pressure: response held 10 cycles while requester 1 waits
      resp_ready = 1'b0;
      post(0, 5, 1'b0, 1'b0);
      n = 0;
      while (!resp_valid && n < 20) begin step(); n++; end
      check("bp_resp_valid", resp_valid, 1);
      post(1, 3, 1'b0, 1'b0);
      any_fired = '0;
      repeat (10) begin step(); any_fired |= last_fired; end
      check("bp_no_accept", any_fired, 0);
      check("bp_resp_id", resp_id, 0);
      check("bp_resp_data", resp_data, 1);
      resp_ready = 1'b1;
      wait_idle(50);

      // exhaustive truth table from requester 0
      do_reset();
      for (int op = 0; op < 8; op++) begin
         for (int ab = 0; ab < 4; ab++) begin
            post(0, op, 1'(ab >> 1), 1'(ab & 1));
            wait_idle(50);
         end
      end
      check("tt_op_count", op_count, 32);
      check("sat_op_count", op_count_s, 7);

      // randomized traffic with random back-pressure
      repeat (400) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 2) == 0) post(i, $urandom_range(0, 7), 1'($urandom), 1'($urandom));
         end
         resp_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      resp_ready = 1'b1;
      wait_idle(300);
      check("sat_hold", op_count_s, 7);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
